// File: rtl/pc_unit.sv
// pc_unit: program counter with jump/flush FSM and optional return-address stack.
//
// Optional feature: define PC_RAS_EN to build the RAS_DEPTH-entry circular
// return-address stack (call/ret). Without it, call/ret are ignored and
// ras_err is tied low.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous clear (pc and state only; stack and ras_err kept)
//   step        in   execute-stage strobe qualifying jmp/call/ret
//   load_val    in   16-bit jump/call target
//   jmp         in   {lt, eq, gt} jump condition bits
//   zr, ng      in   ALU zero / negative flags
//   call, ret   in   return-stack push / pop requests
//   fetch_ready in   instruction memory accepts the current address
//   pc          out  registered fetch address
//   fetch_valid out  pc is a valid fetch request (RUN state)
//   jump_taken  out  one-cycle pulse per redirect
//   ras_err     out  sticky return-stack underflow flag
module pc_unit #(
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        step,
  input  logic [15:0] load_val,
  input  logic [2:0]  jmp,
  input  logic        zr,
  input  logic        ng,
  input  logic        call,
  input  logic        ret,
  input  logic        fetch_ready,
  output logic [15:0] pc,
  output logic        fetch_valid,
  output logic        jump_taken,
  output logic        ras_err
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, pc_inc, pop_val;
  logic        fetch_valid_q, jump_taken_q;
  logic        take, redir, do_pop, call_en;
  assign take   = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
  assign pc_inc = pc_q + 16'd1;
`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(RAS_DEPTH);
  logic [15:0] ras_q [RAS_DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW:0]   cnt_q;
  logic          ras_err_q, empty, do_push;
  assign call_en = call;
  assign empty   = (cnt_q == '0);
  // ret wins over a simultaneous call: pop only
  assign do_pop  = ~clr & step & ret;
  assign do_push = ~clr & step & call & ~ret;
  assign pop_val = empty ? 16'h0000 : ras_q[sp_q - PW'(1)];
  assign ras_err = ras_err_q;
  // Storage needs no reset; only the pointer and occupancy define validity.
  always_ff @(posedge clk)
    if (do_push) ras_q[sp_q] <= pc_inc;
  // Pointer wraps, so a push when full silently replaces the oldest entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sp_q      <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
    end else if (do_pop) begin
      sp_q      <= empty ? sp_q : sp_q - PW'(1);
      cnt_q     <= empty ? cnt_q : cnt_q - (PW+1)'(1);
      ras_err_q <= ras_err_q | empty;
    end else if (do_push) begin
      sp_q  <= sp_q + PW'(1);
      cnt_q <= (cnt_q == FULL) ? cnt_q : cnt_q + (PW+1)'(1);
    end
`else
  logic unused_ras;
  assign unused_ras = call ^ ret ^ (RAS_DEPTH > 16);
  assign call_en    = 1'b0;
  assign do_pop     = 1'b0;
  assign pop_val    = 16'h0000;
  assign ras_err    = 1'b0;
`endif
  // A redirect always beats the fetch handshake; its increment is dropped.
  always_comb begin
    redir   = ~clr & (do_pop | (step & (take | call_en)));
    state_d = clr ? BOOT : redir ? FLUSH : RUN;
    pc_d    = clr ? 16'h0000 :
              do_pop ? pop_val :
              redir ? load_val :
              (state_q == RUN && fetch_ready) ? pc_inc : pc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= 16'h0000;
      fetch_valid_q <= 1'b0;
      jump_taken_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= (state_d == RUN);
      jump_taken_q  <= redir;
    end
  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign jump_taken  = jump_taken_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and random checks of pc_unit against a queue-based model.
module tb_pc_unit;
  localparam int D = 4;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  logic        clk = 0, rst_n = 0, clr = 0, step = 0, zr = 0, ng = 0;
  logic        call = 0, ret = 0, fetch_ready = 0;
  logic [15:0] load_val = 0;
  logic [2:0]  jmp = 0;
  logic [15:0] pc;
  logic        fetch_valid, jump_taken, ras_err;
  int n_chk = 0, n_fail = 0;
  int m_pc = 0;
  bit m_fv = 0, m_jt = 0, m_err = 0;
  int m_stk[$];

  always #5 clk = ~clk;

  pc_unit #(.RAS_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .step(step), .load_val(load_val),
    .jmp(jmp), .zr(zr), .ng(ng), .call(call), .ret(ret),
    .fetch_ready(fetch_ready), .pc(pc), .fetch_valid(fetch_valid),
    .jump_taken(jump_taken), .ras_err(ras_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] e;
    e = m_pc[15:0];
    chk({tag, ".pc"}, pc, e);
    chk({tag, ".fetch_valid"}, {15'b0, fetch_valid}, {15'b0, m_fv});
    chk({tag, ".jump_taken"}, {15'b0, jump_taken}, {15'b0, m_jt});
    chk({tag, ".ras_err"}, {15'b0, ras_err}, {15'b0, m_err});
  endtask

  task automatic model_reset();
    m_pc = 0; m_fv = 0; m_jt = 0; m_err = 0;
    m_stk.delete();
  endtask

  // Model predicts the post-edge state from the rules, then one edge is applied.
  task automatic tick(input string tag);
    bit tk;
    int npc;
    tk = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
    if (clr) begin
      npc = 0; m_fv = 0; m_jt = 0;
    end else if (RAS && step && ret) begin
      if (m_stk.size() == 0) begin npc = 0; m_err = 1; end
      else npc = m_stk.pop_back();
      m_fv = 0; m_jt = 1;
    end else if (step && (tk || (RAS && call))) begin
      if (RAS && call) begin
        m_stk.push_back((m_pc + 1) % 65536);
        if (m_stk.size() > D) void'(m_stk.pop_front());
      end
      npc = load_val; m_fv = 0; m_jt = 1;
    end else begin
      npc = (m_fv && fetch_ready) ? (m_pc + 1) % 65536 : m_pc;
      m_fv = 1; m_jt = 0;
    end
    m_pc = npc;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle();
    step = 0; clr = 0; call = 0; ret = 0; jmp = 0;
  endtask

  // Unconditional jump plus the flush cycle; ends in RUN at addr.
  task automatic go(input logic [15:0] addr);
    idle(); step = 1; jmp = 3'b111; load_val = addr;
    tick("go_jump");
    idle();
    tick("go_flush");
  endtask

  initial begin
    #12;
    check_all("reset");
    rst_n = 1;
    fetch_ready = 0;
    tick("boot_to_run");
    chk("boot_fv", {15'b0, fetch_valid}, 16'd1);

    // async reset mid-run at 0x1234
    go(16'h1234);
    chk("at_1234", pc, 16'h1234);
    #3 rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1;
    tick("rst_release");
    chk("rel_fv", {15'b0, fetch_valid}, 16'd1);

    // wrap 0xFFFE -> 0xFFFF, 0x0000, 0x0001
    fetch_ready = 0;
    go(16'hFFFE);
    fetch_ready = 1;
    tick("wrap1"); chk("wrap_ffff", pc, 16'hFFFF);
    tick("wrap2"); chk("wrap_0000", pc, 16'h0000);
    tick("wrap3"); chk("wrap_0001", pc, 16'h0001);

    // conditional eq jump taken, coinciding with a handshake
    zr = 1; ng = 0; step = 1; jmp = 3'b010; load_val = 16'h0040;
    tick("eq_taken");
    chk("eq_pc", pc, 16'h0040);
    chk("eq_jt", {15'b0, jump_taken}, 16'd1);
    chk("eq_fv", {15'b0, fetch_valid}, 16'd0);
    idle();
    tick("eq_flush");
    chk("flush_no_inc", pc, 16'h0040);
    chk("flush_jt_off", {15'b0, jump_taken}, 16'd0);
    zr = 0; step = 1; jmp = 3'b010; load_val = 16'h0040;
    tick("eq_not_taken");
    chk("nt_pc", pc, 16'h0041);
    idle();

    // fetch stall holds pc and fetch_valid
    go(16'h0010);
    fetch_ready = 0;
    for (int i = 0; i < 5; i++) begin
      tick("stall");
      chk("stall_pc", pc, 16'h0010);
      chk("stall_fv", {15'b0, fetch_valid}, 16'd1);
    end

    // jmp=000 never jumps, jmp=111 always
    fetch_ready = 1; step = 1; jmp = 3'b000; zr = 1; ng = 1; load_val = 16'hBEEF;
    tick("never");
    chk("never_jt", {15'b0, jump_taken}, 16'd0);
    jmp = 3'b111; zr = 0; ng = 0;
    tick("always");
    chk("always_pc", pc, 16'hBEEF);
    idle();

    // clr returns to BOOT
    clr = 1;
    tick("clr");
    chk("clr_pc", pc, 16'h0000);
    clr = 0;
    tick("clr_boot_run");

`ifdef PC_RAS_EN
    rst_n = 0; #1; model_reset(); rst_n = 1;
    go(16'h0100);
    step = 1; call = 1; load_val = 16'h0200;
    tick("call");
    chk("call_pc", pc, 16'h0200);
    idle(); tick("call_flush");
    step = 1; ret = 1;
    tick("ret");
    chk("ret_pc", pc, 16'h0101);
    idle(); tick("ret_flush");
    step = 1; ret = 1;
    tick("ret_under");
    chk("under_pc", pc, 16'h0000);
    chk("under_err", {15'b0, ras_err}, 16'd1);
    idle();
    rst_n = 0; #1; model_reset(); rst_n = 1;
    tick("nest_boot");
    for (int i = 0; i <= D; i++) begin
      step = 1; call = 1; load_val = 16'(16'h1000 + i * 16);
      tick("nest_call");
      idle(); tick("nest_call_flush");
    end
    for (int i = 0; i <= D; i++) begin
      step = 1; ret = 1;
      tick("nest_ret");
      chk("nest_err", {15'b0, ras_err}, (i == D) ? 16'd1 : 16'd0);
      idle(); tick("nest_ret_flush");
    end
`else
    step = 1; call = 1; ret = 1; jmp = 3'b000; fetch_ready = 1;
    tick("ras_off");
    chk("ras_off_jt", {15'b0, jump_taken}, 16'd0);
    chk("ras_off_err", {15'b0, ras_err}, 16'd0);
    idle();
`endif

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      clr         = ($urandom_range(0, 15) == 0);
      step        = ($urandom_range(0, 2) == 0);
      jmp         = 3'($urandom);
      zr          = 1'($urandom);
      ng          = 1'($urandom);
      call        = ($urandom_range(0, 3) == 0);
      ret         = ($urandom_range(0, 3) == 0);
      fetch_ready = 1'($urandom);
      load_val    = 16'($urandom);
      tick("rand");
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RAS_DEPTH, default 4, return-stack entries (power of two, 2..16); used only with PC_RAS_EN.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset: asynchronous, active-low.
REQ-004 SHALL have port clr  input  1  synchronous clear request.
REQ-005 SHALL have port step  input  1  execute-stage advance strobe; jmp, call and ret are sampled only when step=1.
REQ-006 SHALL have port load_val  input  16  jump target, driven from the Mux16 address select.
REQ-007 SHALL have port jmp  input  3  jump bits {j1 lt, j2 eq, j3 gt}.
REQ-008 SHALL have port zr, ng  input  1 each  ALU zero/negative flags.
REQ-009 SHALL have port call, ret  input  1 each  return-stack push/pop requests.
REQ-010 SHALL have port fetch_ready  input  1  instruction memory accepts address.
REQ-011 SHALL have port pc  output  16  current fetch address, registered.
REQ-012 SHALL have port fetch_valid  output  1  pc is a valid fetch request.
REQ-013 SHALL have port jump_taken  output  1  registered, one-cycle pulse per redirect.
REQ-014 SHALL have port ras_err  output  1  sticky return-stack underflow flag.

Function
REQ-015 SHALL implement FSM states BOOT, RUN, FLUSH; BOOT->RUN after one cycle.
REQ-016 SHALL hold fetch_valid=0 in BOOT and FLUSH, and fetch_valid=1 in RUN.
REQ-017 SHALL compute take = (jmp[2]&ng) | (jmp[1]&zr) | (jmp[0]&~ng&~zr); jmp=3'b111 is unconditional; jmp=3'b000 never jumps.
REQ-018 SHALL update pc on each clk edge using this priority: clr -> 0x0000, state BOOT; else step&ret -> popped address; else step&(take|call) -> load_val; else fetch_valid&fetch_ready -> pc+1; else hold.
REQ-019 SHALL make any redirect (clr excluded) pulse jump_taken=1 for one cycle and enter FLUSH for exactly one cycle, then RUN.
REQ-020 SHALL NOT increment pc in FLUSH, even with fetch_ready=1.
REQ-021 SHALL hold pc and fetch_valid stable while fetch_valid=1 and fetch_ready=0.
REQ-022 SHALL increment pc modulo 2^16, so 0xFFFF+1 = 0x0000 with no flag.
REQ-023 SHALL let a redirect that coincides with a fetch_valid&fetch_ready handshake win; that increment is discarded.
REQ-024 SHALL treat step=1 during BOOT or FLUSH as a valid redirect.

Reset
REQ-025 SHALL on rst_n=0 immediately set pc=0x0000, fetch_valid=0, jump_taken=0, ras_err=0, state BOOT, stack pointer 0, all independent of clk.
REQ-026 SHALL, on rst_n deassertion, take its first action on the next clk edge: BOOT->RUN.
REQ-027 SHALL, on clr, reset pc and state but preserve stack contents and ras_err.

Configuration
REQ-028 SHALL be controlled by macro PC_RAS_EN.
REQ-029 SHALL, with PC_RAS_EN defined, implement a RAS_DEPTH-entry circular stack: call pushes pc+1 (mod 2^16) and loads load_val; ret pops into pc.
REQ-030 SHALL, with PC_RAS_EN defined, overwrite the oldest entry on a push when full, with no error.
REQ-031 SHALL, with PC_RAS_EN defined, load 0x0000 and set ras_err on a pop when empty.
REQ-032 SHALL, with PC_RAS_EN defined, give ret priority when call and ret occur together: pop only, no push.
REQ-033 SHALL, without PC_RAS_EN, ignore call and ret, tie ras_err to 0 and instantiate no stack storage.

Verification
REQ-034 SHALL cover: rst_n low mid-run with pc=0x1234 -> pc=0x0000 and fetch_valid=0 asynchronously; first edge after release -> RUN, fetch_valid=1.
REQ-035 SHALL cover: fetch_ready held 1 from pc=0xFFFE for 3 cycles -> pc 0xFFFF, 0x0000, 0x0001.
REQ-036 SHALL cover: step=1, jmp=3'b010, zr=1, load_val=0x0040 -> next pc=0x0040, jump_taken pulse, fetch_valid=0 one cycle; same stimulus with zr=0 -> pc increments.
REQ-037 SHALL cover: fetch_ready=0 for 5 cycles at pc=0x0010 -> pc remains 0x0010 and fetch_valid remains 1.
REQ-038 SHALL cover, with PC_RAS_EN: call at pc=0x0100 to 0x0200, then ret -> pc=0x0101; a further ret -> pc=0x0000 and ras_err=1.
REQ-039 SHALL cover, with PC_RAS_EN: RAS_DEPTH+1 nested calls then RAS_DEPTH+1 rets -> last ret underflows and ras_err=1.
